// File: rtl/usb_pkt_rx_if.sv
// Receive-side byte stream from the USB PHY/UTMI layer into the packet decoder.
//   rx_active : high for the duration of one packet, falling edge marks EOP
//   rx_valid  : rx_data carries a new byte this cycle
//   rx_data   : received byte, bit 0 is the first bit on the wire
// master = PHY side (drives), slave = packet decoder (receives).
interface usb_pkt_rx_if;
  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (output rx_active, rx_valid, rx_data);
  modport slave  (input  rx_active, rx_valid, rx_data);
endinterface

// File: rtl/usb_pkt_rx.sv
// USB packet receiver: decodes the PID, checks CRC5 on tokens and CRC16 on
// DATA packets, checks packet lengths, and publishes the last good token,
// DATA payload and handshake PID with one-cycle update/error pulses.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   rx            : byte stream from the PHY (usb_pkt_rx_if.slave)
//   token         : {pid[3:0], pid[7:4], byte1, byte2} of last good token
//   token_valid   : pulse when token updates; firtsPachet pulses with it
//   setup_data    : last good DATA packet bytes, first byte in the MSBs
//   data_valid    : pulse when setup_data/data_len update
//   data_len      : byte count (PID+payload+CRC16) of last good DATA packet
//   hsk_pid       : pid[3:0] of last good handshake; hsk_valid pulses on update
//   pid_err, crc_err, len_err : one-cycle error pulses, at most one per packet
module usb_pkt_rx #(
  parameter int unsigned MAX_BYTES = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  usb_pkt_rx_if.slave            rx,
  output logic [23:0]            token,
  output logic                   token_valid,
  output logic                   firtsPachet,
  output logic [8*MAX_BYTES-1:0] setup_data,
  output logic                   data_valid,
  output logic [3:0]             data_len,
  output logic [3:0]             hsk_pid,
  output logic                   hsk_valid,
  output logic                   pid_err,
  output logic                   crc_err,
  output logic                   len_err
);

  localparam int unsigned    CW             = $clog2(MAX_BYTES + 2);
  localparam logic [CW-1:0]  CNT_MAX        = CW'(MAX_BYTES);
  localparam logic [CW-1:0]  CNT_SAT        = CW'(MAX_BYTES + 1);
  localparam logic [4:0]     CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0]    CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {IDLE, PID, TOKEN, DATA, HSK, DISCARD} state_t;

  // Serial CRC steps, LSB of the byte first; register MSB is the x^(n-1) term.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    logic       fb;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = d[i] ^ r[4];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = d[i] ^ r[15];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic                   wait_eop_q, wait_eop_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [4:0]             crc5_q, crc5_d;
  logic [15:0]            crc16_q, crc16_d;
  logic [7:0]             pid_q, pid_d;
  logic [15:0]            tok_bytes_q, tok_bytes_d;
  logic [8*MAX_BYTES-1:0] buf_q, buf_d;
  logic [23:0]            token_q, token_d;
  logic                   token_valid_q, token_valid_d;
  logic [8*MAX_BYTES-1:0] setup_data_q, setup_data_d;
  logic                   data_valid_q, data_valid_d;
  logic [3:0]             data_len_q, data_len_d;
  logic [3:0]             hsk_pid_q, hsk_pid_d;
  logic                   hsk_valid_q, hsk_valid_d;
  logic                   pid_err_q, pid_err_d;
  logic                   crc_err_q, crc_err_d;
  logic                   len_err_q, len_err_d;

  logic          byte_in;
  logic          eop;
  logic          pid_good;
  logic [CW-1:0] cnt_inc;

  assign byte_in  = rx.rx_active & rx.rx_valid;
  assign eop      = ~rx.rx_active;
  assign pid_good = (rx.rx_data[7:4] == ~rx.rx_data[3:0]) && (rx.rx_data[1:0] != 2'b00);
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wait_eop_q    <= 1'b1;
      cnt_q         <= '0;
      crc5_q        <= '0;
      crc16_q       <= '0;
      pid_q         <= '0;
      tok_bytes_q   <= '0;
      buf_q         <= '0;
      token_q       <= '0;
      token_valid_q <= 1'b0;
      setup_data_q  <= '0;
      data_valid_q  <= 1'b0;
      data_len_q    <= '0;
      hsk_pid_q     <= '0;
      hsk_valid_q   <= 1'b0;
      pid_err_q     <= 1'b0;
      crc_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_eop_q    <= wait_eop_d;
      cnt_q         <= cnt_d;
      crc5_q        <= crc5_d;
      crc16_q       <= crc16_d;
      pid_q         <= pid_d;
      tok_bytes_q   <= tok_bytes_d;
      buf_q         <= buf_d;
      token_q       <= token_d;
      token_valid_q <= token_valid_d;
      setup_data_q  <= setup_data_d;
      data_valid_q  <= data_valid_d;
      data_len_q    <= data_len_d;
      hsk_pid_q     <= hsk_pid_d;
      hsk_valid_q   <= hsk_valid_d;
      pid_err_q     <= pid_err_d;
      crc_err_q     <= crc_err_d;
      len_err_q     <= len_err_d;
    end
  end

  // Next-state logic. wait_eop_q holds off packet start after a reset that
  // lands mid-packet, so the tail of that packet is never decoded.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rx.rx_active && !wait_eop_q) state_d = PID;
      PID: begin
        if (eop) begin
          state_d = IDLE;
        end else if (rx.rx_valid) begin
          if (!pid_good) begin
            state_d = DISCARD;
          end else begin
            unique case (rx.rx_data[1:0])
              2'b01:   state_d = TOKEN;
              2'b11:   state_d = DATA;
              default: state_d = HSK;
            endcase
          end
        end
      end
      TOKEN, HSK: if (eop) state_d = IDLE;
      DATA: begin
        if (eop)                             state_d = IDLE;
        else if (byte_in && cnt_q >= CNT_MAX) state_d = DISCARD;
      end
      DISCARD: if (eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic. cnt_q counts every byte including the PID.
  always_comb begin
    wait_eop_d    = wait_eop_q & rx.rx_active;
    cnt_d         = cnt_q;
    crc5_d        = crc5_q;
    crc16_d       = crc16_q;
    pid_d         = pid_q;
    tok_bytes_d   = tok_bytes_q;
    buf_d         = buf_q;
    token_d       = token_q;
    setup_data_d  = setup_data_q;
    data_len_d    = data_len_q;
    hsk_pid_d     = hsk_pid_q;
    token_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    hsk_valid_d   = 1'b0;
    pid_err_d     = 1'b0;
    crc_err_d     = 1'b0;
    len_err_d     = 1'b0;

    unique case (state_q)
      PID: begin
        if (byte_in) begin
          pid_d                         = rx.rx_data;
          cnt_d                         = CW'(1);
          crc5_d                        = '1;
          crc16_d                       = '1;
          tok_bytes_d                   = '0;
          buf_d                         = '0;
          buf_d[8*MAX_BYTES-1 -: 8]     = rx.rx_data;
          if (!pid_good) pid_err_d      = 1'b1;
        end
      end
      TOKEN: begin
        if (byte_in) begin
          cnt_d  = cnt_inc;
          crc5_d = crc5_byte(crc5_q, rx.rx_data);
          if (cnt_q == CW'(1))      tok_bytes_d[15:8] = rx.rx_data;
          else if (cnt_q == CW'(2)) tok_bytes_d[7:0]  = rx.rx_data;
        end else if (eop) begin
          if (cnt_q != CW'(3)) begin
            len_err_d = 1'b1;
          end else if (crc5_q != CRC5_RESIDUAL) begin
            crc_err_d = 1'b1;
          end else begin
            token_d       = {pid_q[3:0], pid_q[7:4], tok_bytes_q};
            token_valid_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (byte_in) begin
          if (cnt_q >= CNT_MAX) begin
            len_err_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            crc16_d = crc16_byte(crc16_q, rx.rx_data);
            for (int unsigned i = 1; i < MAX_BYTES; i++) begin
              if (cnt_q == CW'(i)) buf_d[8*(MAX_BYTES-1-i) +: 8] = rx.rx_data;
            end
          end
        end else if (eop) begin
          if (cnt_q < CW'(3)) begin
            len_err_d = 1'b1;
          end else if (crc16_q != CRC16_RESIDUAL) begin
            crc_err_d = 1'b1;
          end else begin
            setup_data_d = buf_q;
            data_len_d   = 4'(cnt_q);
            data_valid_d = 1'b1;
          end
        end
      end
      HSK: begin
        if (byte_in) begin
          cnt_d = cnt_inc;
        end else if (eop) begin
          if (cnt_q != CW'(1)) begin
            len_err_d = 1'b1;
          end else begin
            hsk_pid_d   = pid_q[3:0];
            hsk_valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign token       = token_q;
  assign token_valid = token_valid_q;
  assign firtsPachet = token_valid_q;
  assign setup_data  = setup_data_q;
  assign data_valid  = data_valid_q;
  assign data_len    = data_len_q;
  assign hsk_pid     = hsk_pid_q;
  assign hsk_valid   = hsk_valid_q;
  assign pid_err     = pid_err_q;
  assign crc_err     = crc_err_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_usb_pkt_rx.sv
// Testbench for usb_pkt_rx: directed packets plus randomized traffic checked
// against a packet-level reference model (CRCs computed in generator form,
// outcome decided per whole packet).
module tb_usb_pkt_rx;
  localparam int unsigned MAXB = 12;
  localparam int OC_NONE = 0, OC_TOK = 1, OC_DATA = 2, OC_HSK = 3,
                 OC_PID = 4, OC_CRC = 5, OC_LEN = 6;

  logic clk = 1'b0;
  logic rst;
  usb_pkt_rx_if rxif ();

  logic [23:0]       token;
  logic              token_valid, firtsPachet, data_valid, hsk_valid;
  logic [8*MAXB-1:0] setup_data;
  logic [3:0]        data_len, hsk_pid;
  logic              pid_err, crc_err, len_err;

  usb_pkt_rx #(.MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .rx(rxif),
    .token(token), .token_valid(token_valid), .firtsPachet(firtsPachet),
    .setup_data(setup_data), .data_valid(data_valid), .data_len(data_len),
    .hsk_pid(hsk_pid), .hsk_valid(hsk_valid),
    .pid_err(pid_err), .crc_err(crc_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Pulse counters sampled on the falling edge.
  int unsigned c_tok = 0, c_first = 0, c_data = 0, c_hsk = 0, c_pid = 0, c_crc = 0, c_len = 0;
  int unsigned s_tok, s_first, s_data, s_hsk, s_pid, s_crc, s_len;
  always @(negedge clk) begin
    if (token_valid) c_tok++;
    if (firtsPachet) c_first++;
    if (data_valid)  c_data++;
    if (hsk_valid)   c_hsk++;
    if (pid_err)     c_pid++;
    if (crc_err)     c_crc++;
    if (len_err)     c_len++;
  end

  logic [134:0] all_out;
  assign all_out = {token, token_valid, firtsPachet, setup_data, data_valid,
                    data_len, hsk_pid, hsk_valid, pid_err, crc_err, len_err};
  logic [127:0] held_out;
  assign held_out = {token, setup_data, data_len, hsk_pid};

  // Reference model state.
  logic [23:0]       exp_token = '0;
  logic [8*MAXB-1:0] exp_setup = '0;
  logic [3:0]        exp_len = '0, exp_hsk = '0;
  logic [7:0]        pkt_q[$];
  int                oc;

  logic [7:0] tok_pids[4] = '{8'hE1, 8'h69, 8'hA5, 8'h2D};
  logic [7:0] dat_pids[4] = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
  logic [7:0] hsk_pids[4] = '{8'hD2, 8'h5A, 8'h1E, 8'h96};

  function automatic logic [4:0] crc5_ref(input logic [10:0] v);
    logic [4:0] c = 5'h1F;
    for (int i = 0; i < 11; i++) c = (c[0] ^ v[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return ~c;
  endfunction

  function automatic logic [15:0] crc16_ref(input int first, input int last);
    logic [15:0] c = 16'hFFFF;
    for (int i = first; i <= last; i++) begin
      c = c ^ {8'h00, pkt_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  // Whole-packet outcome; updates the held expected outputs on acceptance.
  function automatic int model_pkt();
    int          n = pkt_q.size();
    logic [7:0]  p;
    logic [15:0] f, c16;
    if (n == 0) return OC_NONE;
    p = pkt_q[0];
    if (p[7:4] != ~p[3:0] || p[1:0] == 2'b00) return OC_PID;
    if (p[1:0] == 2'b01) begin
      if (n != 3) return OC_LEN;
      f = {pkt_q[2], pkt_q[1]};
      if (crc5_ref(f[10:0]) != f[15:11]) return OC_CRC;
      exp_token = {p[3:0], p[7:4], pkt_q[1], pkt_q[2]};
      return OC_TOK;
    end
    if (p[1:0] == 2'b11) begin
      if (n > MAXB || n < 3) return OC_LEN;
      c16 = crc16_ref(1, n - 3);
      if ({pkt_q[n-1], pkt_q[n-2]} != c16) return OC_CRC;
      exp_setup = '0;
      for (int i = 0; i < n; i++) exp_setup[8*(MAXB-1-i) +: 8] = pkt_q[i];
      exp_len = 4'(n);
      return OC_DATA;
    end
    if (n != 1) return OC_LEN;
    exp_hsk = p[3:0];
    return OC_HSK;
  endfunction

  // Pulse vector layout: {tok, first, data, hsk, pid, crc, len}, 4 bits each.
  function automatic logic [27:0] exp_vec(input int o);
    logic [27:0] v = '0;
    case (o)
      OC_TOK:  v[27:20] = 8'h11;
      OC_DATA: v[19:16] = 4'd1;
      OC_HSK:  v[15:12] = 4'd1;
      OC_PID:  v[11:8]  = 4'd1;
      OC_CRC:  v[7:4]   = 4'd1;
      OC_LEN:  v[3:0]   = 4'd1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [27:0] obs_vec();
    return {4'(c_tok - s_tok), 4'(c_first - s_first), 4'(c_data - s_data),
            4'(c_hsk - s_hsk), 4'(c_pid - s_pid), 4'(c_crc - s_crc), 4'(c_len - s_len)};
  endfunction

  task automatic snap();
    s_tok = c_tok; s_first = c_first; s_data = c_data; s_hsk = c_hsk;
    s_pid = c_pid; s_crc = c_crc; s_len = c_len;
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic pkt_begin();
    rxif.rx_active = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    rxif.rx_valid = 1'b1;
    rxif.rx_data  = b;
    @(posedge clk); #1;
    rxif.rx_valid = 1'b0;
    rxif.rx_data  = 8'($urandom());
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic pkt_end();
    rxif.rx_active = 1'b0;
    rxif.rx_valid  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic run_pkt(input int unsigned gap_max);
    snap();
    pkt_begin();
    foreach (pkt_q[i]) send_byte(pkt_q[i], $urandom_range(gap_max, 0));
    pkt_end();
  endtask

  task automatic gen_good(input int unsigned kind);
    logic [10:0] v;
    logic [15:0] c;
    pkt_q.delete();
    case (kind)
      0: begin
        v = 11'($urandom());
        c = {11'd0, crc5_ref(v)};
        pkt_q.push_back(tok_pids[$urandom_range(3, 0)]);
        pkt_q.push_back(v[7:0]);
        pkt_q.push_back({c[4:0], v[10:8]});
      end
      1: begin
        pkt_q.push_back(dat_pids[$urandom_range(3, 0)]);
        repeat ($urandom_range(MAXB - 3, 0)) pkt_q.push_back(8'($urandom()));
        c = crc16_ref(1, pkt_q.size() - 1);
        pkt_q.push_back(c[7:0]);
        pkt_q.push_back(c[15:8]);
      end
      default: pkt_q.push_back(hsk_pids[$urandom_range(3, 0)]);
    endcase
  endtask

  task automatic gen_random_pkt();
    int unsigned r = $urandom_range(9, 0);
    int unsigned idx;
    if (r <= 2)      gen_good(0);
    else if (r <= 5) gen_good(1);
    else if (r == 6) gen_good(2);
    else if (r <= 8) begin
      gen_good($urandom_range(2, 0));
      idx = $urandom_range(pkt_q.size() - 1, 0);
      pkt_q[idx] = pkt_q[idx] ^ (8'h01 << $urandom_range(7, 0));
    end else begin
      pkt_q.delete();
      case ($urandom_range(3, 0))
        0: pkt_q.push_back(tok_pids[$urandom_range(3, 0)]);
        1: pkt_q.push_back(dat_pids[$urandom_range(3, 0)]);
        2: pkt_q.push_back(hsk_pids[$urandom_range(3, 0)]);
        default: pkt_q.push_back(8'($urandom()));
      endcase
      repeat ($urandom_range(14, 0)) pkt_q.push_back(8'($urandom()));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxif.rx_active = 1'b0; rxif.rx_valid = 1'b0; rxif.rx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_in: outputs=%h expected 0", all_out);
    end
    snap();
    rst = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    tests_run++;
    if ({all_out, obs_vec()} !== '0) begin
      tests_failed++;
      $display("FAIL reset_out: outputs=%h pulses=%h expected 0", all_out, obs_vec());
    end
  endtask

  task automatic test_token();
    pkt_q = '{8'h2D, 8'h00, 8'h10};
    run_pkt(2);
    oc = model_pkt();
    tests_run++;
    if (obs_vec() !== exp_vec(oc)) begin
      tests_failed++;
      $display("FAIL token_pulses: got %h expected %h", obs_vec(), exp_vec(oc));
    end
    tests_run++;
    if (token !== 24'hD20010) begin
      tests_failed++;
      $display("FAIL token_value: got %h expected d20010", token);
    end
  endtask

  task automatic test_data();
    pkt_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    run_pkt(2);
    oc = model_pkt();
    tests_run++;
    if (obs_vec() !== exp_vec(OC_DATA) || oc != OC_DATA) begin
      tests_failed++;
      $display("FAIL data_pulses: got %h expected %h", obs_vec(), exp_vec(OC_DATA));
    end
    tests_run++;
    if ({setup_data, data_len} !== {96'hC380_0600_0100_0040_00DD_9400, 4'd11}) begin
      tests_failed++;
      $display("FAIL data_value: got %h len %0d expected c380060001000040 00dd9400 len 11",
               setup_data, data_len);
    end
  endtask

  task automatic test_hsk_crc();
    pkt_q = '{8'hD2};
    run_pkt(1);
    oc = model_pkt();
    tests_run++;
    if (obs_vec() !== exp_vec(oc) || hsk_pid !== 4'h2) begin
      tests_failed++;
      $display("FAIL hsk: pulses %h hsk_pid %h expected %h / 2", obs_vec(), hsk_pid, exp_vec(oc));
    end
    pkt_q = '{8'h2D, 8'h00, 8'h11};
    run_pkt(1);
    oc = model_pkt();
    tests_run++;
    if (obs_vec() !== exp_vec(OC_CRC) || oc != OC_CRC) begin
      tests_failed++;
      $display("FAIL token_crc_err: got %h expected %h", obs_vec(), exp_vec(OC_CRC));
    end
    tests_run++;
    if (token !== 24'hD20010) begin
      tests_failed++;
      $display("FAIL token_hold: got %h expected d20010", token);
    end
  endtask

  task automatic test_pid_err();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) pkt_q = '{8'h2E, 8'h00, 8'h10, 8'h55};
      else        pkt_q = '{8'h3C, 8'h01, 8'h02};
      run_pkt(1);
      oc = model_pkt();
      tests_run++;
      if (obs_vec() !== exp_vec(OC_PID) || held_out !== {exp_token, exp_setup, exp_len, exp_hsk}) begin
        tests_failed++;
        $display("FAIL pid_err_%0d: pulses %h held %h expected %h / %h", k, obs_vec(), held_out,
                 exp_vec(OC_PID), {exp_token, exp_setup, exp_len, exp_hsk});
      end
    end
  endtask

  task automatic test_len();
    pkt_q.delete();
    pkt_q.push_back(8'hC3);
    repeat (14) pkt_q.push_back(8'($urandom()));
    snap();
    pkt_begin();
    for (int i = 0; i < 12; i++) send_byte(pkt_q[i], 0);
    tests_run++;
    if (4'(c_len - s_len) !== 4'd0) begin
      tests_failed++;
      $display("FAIL len_early: len_err count %0d expected 0 after 12 bytes", c_len - s_len);
    end
    send_byte(pkt_q[12], 0);
    @(posedge clk); #1;
    tests_run++;
    if (4'(c_len - s_len) !== 4'd1) begin
      tests_failed++;
      $display("FAIL len_at_13: len_err count %0d expected 1", c_len - s_len);
    end
    for (int i = 13; i < 15; i++) send_byte(pkt_q[i], 1);
    pkt_end();
    oc = model_pkt();
    tests_run++;
    if (obs_vec() !== exp_vec(oc) || held_out !== {exp_token, exp_setup, exp_len, exp_hsk}) begin
      tests_failed++;
      $display("FAIL len_overflow: pulses %h held %h expected %h / %h", obs_vec(), held_out,
               exp_vec(oc), {exp_token, exp_setup, exp_len, exp_hsk});
    end
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: pkt_q = '{8'hC3};
        1: pkt_q = '{8'h4B, 8'h00};
        2: pkt_q = '{8'h2D, 8'h00};
        3: pkt_q = '{8'h2D, 8'h00, 8'h10, 8'h00};
        default: pkt_q = '{8'hD2, 8'h00};
      endcase
      run_pkt(1);
      oc = model_pkt();
      tests_run++;
      if (obs_vec() !== exp_vec(OC_LEN) || oc != OC_LEN) begin
        tests_failed++;
        $display("FAIL len_short_%0d: got %h expected %h", k, obs_vec(), exp_vec(OC_LEN));
      end
    end
  endtask

  task automatic test_silent();
    snap();
    rxif.rx_valid = 1'b1; rxif.rx_data = 8'h2D;
    repeat (3) begin @(posedge clk); #1; end
    rxif.rx_valid = 1'b0;
    pkt_begin();
    pkt_end();
    tests_run++;
    if (obs_vec() !== 28'd0 || held_out !== {exp_token, exp_setup, exp_len, exp_hsk}) begin
      tests_failed++;
      $display("FAIL silent: pulses %h held %h expected 0 / %h", obs_vec(), held_out,
               {exp_token, exp_setup, exp_len, exp_hsk});
    end
  endtask

  task automatic test_reset_mid();
    pkt_q = '{8'h2D, 8'h00, 8'h10};
    run_pkt(0);
    void'(model_pkt());
    pkt_begin();
    send_byte(8'hC3, 0);
    send_byte(8'h80, 1);
    send_byte(8'h06, 0);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: outputs=%h expected 0", all_out);
    end
    exp_token = '0; exp_setup = '0; exp_len = '0; exp_hsk = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    snap();
    @(posedge clk); #1;
    send_byte(8'h2D, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    pkt_end();
    tests_run++;
    if (obs_vec() !== 28'd0 || held_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_tail: pulses %h held %h expected 0", obs_vec(), held_out);
    end
    pkt_q = '{8'h2D, 8'h00, 8'h10};
    run_pkt(0);
    oc = model_pkt();
    tests_run++;
    if (obs_vec() !== exp_vec(OC_TOK) || token !== 24'hD20010) begin
      tests_failed++;
      $display("FAIL reset_next: pulses %h token %h expected %h / d20010", obs_vec(), token,
               exp_vec(OC_TOK));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      gen_good(k % 3);
      run_pkt(0);
      oc = model_pkt();
      tests_run++;
      if (obs_vec() !== exp_vec(oc) || held_out !== {exp_token, exp_setup, exp_len, exp_hsk}) begin
        tests_failed++;
        $display("FAIL b2b_%0d: pulses %h held %h expected %h / %h", k, obs_vec(), held_out,
                 exp_vec(oc), {exp_token, exp_setup, exp_len, exp_hsk});
      end
    end
  endtask

  task automatic test_random(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      gen_random_pkt();
      run_pkt(2);
      oc = model_pkt();
      tests_run++;
      if (obs_vec() !== exp_vec(oc)) begin
        tests_failed++;
        $display("FAIL rand_pulses_%0d: got %h expected %h (outcome %0d, %0d bytes)", k,
                 obs_vec(), exp_vec(oc), oc, pkt_q.size());
      end
      tests_run++;
      if (held_out !== {exp_token, exp_setup, exp_len, exp_hsk}) begin
        tests_failed++;
        $display("FAIL rand_held_%0d: got %h expected %h", k, held_out,
                 {exp_token, exp_setup, exp_len, exp_hsk});
      end
    end
  endtask

  initial begin
    test_reset();
    test_token();
    test_data();
    test_hsk_crc();
    test_pid_err();
    test_len();
    test_silent();
    test_reset_mid();
    test_back_to_back();
    test_random(200);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/usb_pkt_rx.md
USB_PKT_RX -- requirements
Module: usb_pkt_rx

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 12, meaning the maximum DATA packet length in bytes, including PID and CRC16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rx_active, input, 1 bit: high for the duration of one packet; its deassertion marks EOP.
REQ-005 SHALL have port rx_valid, input, 1 bit: rx_data holds a new byte this cycle; ignored while rx_active=0.
REQ-006 SHALL have port rx_data, input, 8 bits: received byte, PID first; within a byte, bit 0 is the first bit on the wire.
REQ-007 SHALL have port token, output, 24 bits: {pid[3:0], pid[7:4], byte1, byte2} of the last good token packet.
REQ-008 SHALL have port token_valid, output, 1 bit: one-cycle pulse when token updates.
REQ-009 SHALL have port firtsPachet, output, 1 bit: one-cycle pulse coincident with token_valid.
REQ-010 SHALL have port setup_data, output, 96 bits: last good DATA packet bytes, first byte in bits 95:88, unused low bytes zero.
REQ-011 SHALL have port data_valid, output, 1 bit: one-cycle pulse when setup_data updates.
REQ-012 SHALL have port data_len, output, 4 bits: byte count of the last good DATA packet.
REQ-013 SHALL have port hsk_pid, output, 4 bits: pid[3:0] of the last good handshake packet.
REQ-014 SHALL have port hsk_valid, output, 1 bit: one-cycle pulse when hsk_pid updates.
REQ-015 SHALL have ports pid_err, crc_err and len_err, each output, 1 bit: one-cycle error pulses.

Function
REQ-016 SHALL implement FSM states IDLE, PID, TOKEN, DATA, HSK, DISCARD; IDLE -> PID on rx_active=1.
REQ-017 SHALL, in PID, take the first valid byte and flag pid_err unless pid[7:4] == ~pid[3:0]; on error go to DISCARD.
REQ-018 SHALL classify pid[1:0]: 01 -> TOKEN (OUT/IN/SOF/SETUP); 11 -> DATA (DATA0/1/2/MDATA); 10 -> HSK (ACK/NAK/STALL/NYET); 00 -> pid_err, DISCARD.
REQ-019 SHALL, in TOKEN, accept exactly 2 bytes and compute CRC5 (poly x^5+x^2+1, init 5'b11111) over all 16 bits, LSB first.
REQ-020 SHALL, at EOP, accept a token only if its residual equals 5'b01100; otherwise it SHALL pulse crc_err.
REQ-021 SHALL, in DATA, store bytes and compute CRC16 (poly x^16+x^15+x^2+1, init 16'hFFFF) over all post-PID bytes, LSB first.
REQ-022 SHALL, at EOP, accept a DATA packet only if its residual equals 16'h800D; otherwise it SHALL pulse crc_err.
REQ-023 SHALL treat a DATA packet with more than MAX_BYTES bytes, or fewer than 3 bytes (PID+CRC16), as len_err, going to DISCARD on overflow.
REQ-024 SHALL treat a token with other than 2 post-PID bytes as len_err, and a handshake with any post-PID byte as len_err.
REQ-025 SHALL detect EOP on the first rising edge sampling rx_active=0 in TOKEN/DATA/HSK.
REQ-026 SHALL register outputs and pulses on that edge, so they are visible the following cycle, and then return to IDLE.
REQ-027 SHALL, in DISCARD, ignore bytes until rx_active=0 and then go to IDLE; only one error pulse is issued per packet.
REQ-028 SHALL count bytes with saturation (no wrap); only one accept or error outcome occurs per packet.
REQ-029 SHALL leave token, setup_data, data_len and hsk_pid holding their previous values on error.
REQ-030 SHALL, when rx_active falls in PID before any byte, return to IDLE silently.

Reset
REQ-031 SHALL, on rst=0 (asynchronous), force state to IDLE and clear all outputs, the CRC registers and the byte counter to 0, including mid-packet.
REQ-032 SHALL, after rst deasserts mid-packet, wait for rx_active=0 before accepting the next PID.

Verification
REQ-033 SHALL cover: bytes 2D 00 10, then EOP -> token=24'hD20010, with token_valid and firtsPachet each pulsing once and no errors.
REQ-034 SHALL cover: C3 80 06 00 01 00 00 40 00 DD 94, then EOP -> data_valid, data_len=11, setup_data[95:8]=the 11 bytes, setup_data[7:0]=0.
REQ-035 SHALL cover: D2, then EOP -> hsk_valid, hsk_pid=4'h2; then 2D 00 11 -> crc_err pulse, with token unchanged.
REQ-036 SHALL cover: PID 2E -> pid_err once, remaining bytes ignored, no valid pulse.
REQ-037 SHALL cover: C3 followed by 12 more bytes -> len_err once at byte 13, with setup_data unchanged.
REQ-038 SHALL cover: rst=0 asserted mid-DATA with rx_active held high -> all outputs 0 immediately, and a following 2D 00 10 packet is accepted only after the ongoing packet ends.
